seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Parametrised, self-scanning multiplexed seven-segment display controller. It owns its refresh timing and cycles one anode at a time across `NUM_DIGITS` digits. Digit values are double-buffered so the display never tears, and the block adds leading-zero blanking, per-digit decimal points and break-before-make anode switching. It sits between the datapath result registers and the board display pins.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits/anodes; ≥ 2.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means anodes and segments are driven low-active; 0 means high-active.

Ports:
- `clk` input, 1: sole clock.
- `reset` input, 1: asynchronous, active-high.
- `en` input, 1: scan enable.
- `load` input, 1: one-cycle strobe; captures `value` and `dp`.
- `value` input, 4*NUM_DIGITS: hex nibbles; nibble i drives digit i; digit 0 is rightmost.
- `dp` input, NUM_DIGITS: decimal-point request per digit.
- `blank_lz` input, 1: leading-zero blanking mode.
- `an` output, NUM_DIGITS: anode drive, registered.
- `seg` output, 8: segments {a,b,c,d,e,f,g,dp} in bits [7:0], registered.
- `frame_done` output, 1: one-cycle pulse at each frame wrap.

## Operation
- Internal segment code is 1 = lit: 0→FC, 1→60, 2→DA, 3→F2, 4→66, 5→B6, 6→BE, 7→E0, 8→FE, 9→F6, A→EE, b→3E, C→9C, d→7A, E→9E, F→8E (bit0 = dp, always 0 from the decoder).
- Both `seg` and `an` are inverted at the output when `ACTIVE_LOW`=1.
- State:
  - `div` counts 0..REFRESH_DIV-1.
  - `idx` counts 0..NUM_DIGITS-1.
  - `pend_val`/`pend_dp`, `disp_val`/`disp_dp` hold the buffered and displayed values.
- Advance, when `en`=1:
  - `div` increments each cycle.
  - When `div`=REFRESH_DIV-1, `div` goes to 0 and `idx` increments.
  - When `idx`=NUM_DIGITS-1 at that point, `idx` wraps to 0. This is the frame wrap.
- Load:
  - `load`=1 writes `value`/`dp` into the pending buffer, regardless of `en`.
  - Back-to-back loads are allowed; the last one before a wrap wins.
- Frame wrap:
  - The display buffer takes the pending buffer.
  - If `load`=1 in the wrap cycle, the display buffer takes `value`/`dp` directly (bypass).
  - `frame_done` is asserted in the next cycle.
- Blanking:
  - Digit i (i ≥ 1) is blanked when `blank_lz`=1 and nibbles i..NUM_DIGITS-1 of `disp_val` are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode slot, shows no a–g segments, and still shows dp if requested.
- Break-before-make: during the `div`=0 cycle of every slot, all anodes are inactive.
- `en`=0:
  - `div`, `idx` and the display buffer are frozen.
  - `an` is all inactive, `seg` is all off, and no `frame_done` is issued.
  - When `en` returns to 1, counting resumes from the frozen state.

## Timing
- Output latency is one cycle. `an`/`seg` in cycle t+1 reflect `div`/`idx`/`disp_*` in cycle t.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Each anode is active REFRESH_DIV-1 cycles per frame.
- Load-to-visible latency is at most one frame plus one cycle.
- Reset values, applied immediately and asynchronously:
  - `div`=0, `idx`=0, all buffers = 0.
  - `an` inactive (all 1 when active-low), `seg`=8'hFF when active-low (8'h00 otherwise), `frame_done`=0.
- Reset mid-scan aborts the frame and discards any pending load.
- The first wrap after reset occurs NUM_DIGITS*REFRESH_DIV cycles after reset release with `en`=1.

## Structure
- Shared package `seg_disp_pkg`:
  - the 16-entry segment code constants;
  - the `SEG_OFF` constant;
  - the segment bit-position constants.
- Sub-module `hex_seg_decoder`: combinational nibble → 8-bit lit-high code. One instance is used, fed by the nibble selected by `idx`.
- Top level contains the counters, the pending/display buffers, the blanking logic, the polarity inversion and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
- **Reset:** assert `reset` mid-scan → `an`=4'b1111, `seg`=8'hFF and `frame_done`=0 immediately; first `frame_done` 16 cycles after release.
- **Scan:** `load` `value`=16'h12AF, `dp`=4'b0100; after the wrap → slots show `an`=1110/`seg`=71, 1101/11, 1011/24, 0111/9F. Each slot opens with one `an`=1111 cycle. `frame_done` pulses every 16 cycles.
- **Blanking:** `blank_lz`=1, `value`=16'h0070 → digits 3,2 show `seg`=FF with anode still active; digit1 shows 1F, digit0 shows 03. `value`=0 → only digit0 shows 03.
- **Tear-free update:** `load` 16'h1111 in the cycle after `idx` becomes 2 → digits 2 and 3 keep the old values for the rest of that frame; all digits show 9F from the next frame.
- **Wrap/load collision:** `load` 16'h8888 in the wrap cycle → the next frame shows 01 on all digits (bypass).
- **Enable gating:** `en`=0 for 10 cycles mid-slot → `an`=1111, `seg`=FF, no `frame_done`; the scan resumes in the same slot with the remaining count when `en`=1.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment display path: lit-high glyph codes,
// the blank code and the bit position of each segment within the 8-bit bus.
package seg_disp_pkg;

    localparam logic [7:0] SEG_HEX_0 = 8'hFC;
    localparam logic [7:0] SEG_HEX_1 = 8'h60;
    localparam logic [7:0] SEG_HEX_2 = 8'hDA;
    localparam logic [7:0] SEG_HEX_3 = 8'hF2;
    localparam logic [7:0] SEG_HEX_4 = 8'h66;
    localparam logic [7:0] SEG_HEX_5 = 8'hB6;
    localparam logic [7:0] SEG_HEX_6 = 8'hBE;
    localparam logic [7:0] SEG_HEX_7 = 8'hE0;
    localparam logic [7:0] SEG_HEX_8 = 8'hFE;
    localparam logic [7:0] SEG_HEX_9 = 8'hF6;
    localparam logic [7:0] SEG_HEX_A = 8'hEE;
    localparam logic [7:0] SEG_HEX_B = 8'h3E;
    localparam logic [7:0] SEG_HEX_C = 8'h9C;
    localparam logic [7:0] SEG_HEX_D = 8'h7A;
    localparam logic [7:0] SEG_HEX_E = 8'h9E;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Everything except the decimal point; cleared on a blanked digit.
    localparam logic [7:0] SEG_AG_MASK =
        (8'b1 << SEG_A_BIT) | (8'b1 << SEG_B_BIT) | (8'b1 << SEG_C_BIT) |
        (8'b1 << SEG_D_BIT) | (8'b1 << SEG_E_BIT) | (8'b1 << SEG_F_BIT) |
        (8'b1 << SEG_G_BIT);

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to lit-high segment code; the dp bit is always 0.
module hex_seg_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] code
);

    always_comb begin
        code = SEG_OFF;
        case (nibble)
            4'h0: code = SEG_HEX_0;
            4'h1: code = SEG_HEX_1;
            4'h2: code = SEG_HEX_2;
            4'h3: code = SEG_HEX_3;
            4'h4: code = SEG_HEX_4;
            4'h5: code = SEG_HEX_5;
            4'h6: code = SEG_HEX_6;
            4'h7: code = SEG_HEX_7;
            4'h8: code = SEG_HEX_8;
            4'h9: code = SEG_HEX_9;
            4'hA: code = SEG_HEX_A;
            4'hB: code = SEG_HEX_B;
            4'hC: code = SEG_HEX_C;
            4'hD: code = SEG_HEX_D;
            4'hE: code = SEG_HEX_E;
            4'hF: code = SEG_HEX_F;
            default: code = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Self-scanning multiplexed seven-segment driver with a double-buffered value,
// leading-zero blanking, per-digit dp and break-before-make anode switching.
module seven_seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;

    logic                    slot_end, wrap;
    logic [3:0]              nibble;
    logic [7:0]              dec_code;
    logic                    upper_nz, blank;
    logic [NUM_DIGITS-1:0]   an_lit;
    logic [7:0]              seg_lit;

    assign slot_end = en && (div == DIV_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign nibble   = disp_val[{idx, 2'b00} +: 4];

    hex_seg_decoder u_dec (
        .nibble (nibble),
        .code   (dec_code)
    );

    // Blank only if this digit and every more-significant digit are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= idx) && (disp_val[4*j +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
        blank = blank_lz && (idx != '0) && !upper_nz;
    end

    always_comb begin
        an_lit = '0;
        for (int j = 0; j < NUM_DIGITS; j++)
            an_lit[j] = en && (div != '0) && (IDX_W'(j) == idx);
        seg_lit = SEG_OFF;
        if (en) begin
            seg_lit             = blank ? (dec_code & ~SEG_AG_MASK) : dec_code;
            seg_lit[SEG_DP_BIT] = disp_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            an         <= ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
            seg        <= ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            if (en) begin
                if (slot_end) begin
                    div <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    div <= div + 1'b1;
                end
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            // A load landing on the wrap cycle goes straight to the display.
            if (wrap) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp : pend_dp;
            end
            an         <= ACTIVE_LOW ? ~an_lit : an_lit;
            seg        <= ACTIVE_LOW ? ~seg_lit : seg_lit;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 4-cycle slots, active-low):
// frame-position model with per-cycle compare plus directed literal checks.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int FRAME = N * R;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp = '0;
    logic          blank_lz = 1'b0;
    logic [3:0]    an;
    logic [7:0]    seg;
    logic          frame_done;

    int checks = 0;
    int failures = 0;
    int edges = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: position within the frame from enabled cycles ----
    logic [13:0] exp_q[$];
    int          pos = 0;
    logic [15:0] m_pend = '0, m_disp = '0;
    logic [3:0]  m_pdp = '0, m_ddp = '0;

    always @(posedge clk or posedge reset) begin
        int d, i;
        logic [3:0] a_e, nib;
        logic [7:0] code;
        logic fd_e, care;
        if (reset) begin
            pos = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
            edges = 0;
            exp_q.delete();
        end else begin
            edges++;
            d = pos % R;
            i = (pos / R) % N;
            if (en) begin
                a_e  = (d == 0) ? 4'hF : ~(4'b1 << i);
                nib  = 4'(m_disp >> (4 * i));
                code = SEG_TAB[nib];
                if (blank_lz && i > 0 && (m_disp >> (4 * i)) == 16'h0) code = 8'h00;
                if (m_ddp[i]) code = code | 8'h01;
                fd_e = ((pos % FRAME) == FRAME - 1);
                care = (d != 0);
            end else begin
                a_e = 4'hF; code = 8'h00; fd_e = 1'b0; care = 1'b1;
            end
            exp_q.push_back({care, a_e, ~code, fd_e});
            if (load) begin m_pend = value; m_pdp = dp; end
            if (en) begin
                if ((pos % FRAME) == FRAME - 1) begin m_disp = m_pend; m_ddp = m_pdp; end
                pos++;
            end
        end
    end

    // ---- scoreboard compare, every cycle ----
    always @(posedge clk) begin
        logic [13:0] e;
        #2;
        if (reset) begin
            check("rst_an", {4'h0, an}, 8'h0F);
            check("rst_seg", seg, 8'hFF);
            check("rst_fd", {7'h0, frame_done}, 8'h00);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mdl_an", {4'h0, an}, {4'h0, e[12:9]});
            check("mdl_fd", {7'h0, frame_done}, {7'h0, e[0]});
            if (e[13]) check("mdl_seg", seg, e[8:1]);
        end
    end

    // ---- driver tasks ----
    task automatic goto(input int n);
        int guard = 0;
        while (edges < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (edges != n) begin
            checks++; failures++;
            $display("FAIL goto_timeout: actual=%0d required=%0d", edges, n);
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] a_exp, input logic [7:0] s_exp);
        check({name, "_an"}, {4'h0, an}, {4'h0, a_exp});
        check({name, "_seg"}, seg, s_exp);
    endtask

    task automatic expect_fd(input string name, input logic f);
        check(name, {7'h0, frame_done}, {7'h0, f});
    endtask

    task automatic do_load(input int at, input logic [15:0] v, input logic [3:0] p);
        goto(at);
        load = 1'b1; value = v; dp = p;
        goto(at + 1);
        load = 1'b0;
    endtask

    // ---- directed stimulus; goto(k+1) observes outputs after edge k ----
    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0; en = 1'b1;
        do_load(0, 16'h12AF, 4'b0100);
        goto(15); expect_fd("fd_before_first", 1'b0);
        goto(16); expect_fd("fd_first", 1'b1);
        goto(17); check("break_an", {4'h0, an}, 8'h0F);
        goto(18); expect_out("scan_d0", 4'b1110, 8'h71);
        do_load(20, 16'h0070, 4'b0000);
        goto(22); expect_out("scan_d1", 4'b1101, 8'h11);
        goto(26); expect_out("scan_d2", 4'b1011, 8'h24);
        goto(30); expect_out("scan_d3", 4'b0111, 8'h9F);
        goto(32); expect_fd("fd_second", 1'b1);
        blank_lz = 1'b1;
        goto(34); expect_out("blank_d0", 4'b1110, 8'h03);
        goto(38); expect_out("blank_d1", 4'b1101, 8'h1F);
        do_load(40, 16'h0000, 4'b0000);
        goto(42); expect_out("blank_d2", 4'b1011, 8'hFF);
        goto(46); expect_out("blank_d3", 4'b0111, 8'hFF);
        goto(50); expect_out("zero_d0", 4'b1110, 8'h03);
        do_load(50, 16'h12AF, 4'b0100);
        goto(54); expect_out("zero_d1", 4'b1101, 8'hFF);
        do_load(73, 16'h1111, 4'b0000);
        goto(75); expect_out("tear_d2_old", 4'b1011, 8'h24);
        goto(78); expect_out("tear_d3_old", 4'b0111, 8'h9F);
        goto(82); expect_out("tear_d0_new", 4'b1110, 8'h9F);
        goto(86); expect_out("tear_d1_new", 4'b1101, 8'h9F);
        goto(90); expect_out("tear_d2_new", 4'b1011, 8'h9F);
        do_load(95, 16'h8888, 4'b0000);
        goto(98); expect_out("bypass_d0", 4'b1110, 8'h01);
        goto(110); expect_out("bypass_d3", 4'b0111, 8'h01);
        goto(111); expect_fd("fd_not_yet", 1'b0);
        goto(112); expect_fd("fd_bypass_frame", 1'b1);
        goto(114); en = 1'b0;
        goto(116); expect_out("gated", 4'b1111, 8'hFF);
        goto(124); en = 1'b1;
        goto(125); expect_out("resume", 4'b1110, 8'h01);
        goto(128); expect_fd("fd_gated_none", 1'b0);
        goto(138); expect_fd("fd_gated_late", 1'b1);
        do_load(139, 16'h5555, 4'b1111);
        @(posedge clk); #4;
        reset = 1'b1;
        #1;
        expect_out("async_rst", 4'b1111, 8'hFF);
        expect_fd("async_rst_fd", 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0; blank_lz = 1'b0;
        goto(15); expect_fd("rst_fd_early", 1'b0);
        goto(16); expect_fd("rst_fd_first", 1'b1);
        goto(18); expect_out("discard_d0", 4'b1110, 8'h03);
        goto(22); expect_out("discard_d1", 4'b1101, 8'h03);
        goto(30); expect_out("discard_d3", 4'b0111, 8'h03);
        goto(34);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
